snn_host_sequencer: RTL and testbench

- Wishbone initiator that drives one neuron core through a complete timestep over the core's Wishbone slave port.
- Per run it: writes the input spike words into the selected core's IMEM window, writes the calc trigger, reads the selected core's OMEM window, and emits the output spike words on a valid/ready stream.
- Sits between the test/host logic (Caravel-side harness or on-chip controller) and the neuron core.

---
 rtl/snn_host_sequencer_if.sv | 37 +++
 rtl/snn_host_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_snn_host_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_host_sequencer_if.sv
// Signal bundle between the host sequencer and its environment.
// The master modport is the sequencer view; slave is the host/core side.
interface snn_host_sequencer_if;
  logic        start_i;
  logic        core_i;
  logic        in_valid_i;
  logic [31:0] in_data_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic        out_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  start_i, core_i, in_valid_i, in_data_i, out_ready_i,
           wbm_ack_i, wbm_dat_i,
    output in_ready_o, out_valid_o, out_data_o, busy_o, done_o, err_o,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output start_i, core_i, in_valid_i, in_data_i, out_ready_i,
           wbm_ack_i, wbm_dat_i,
    input  in_ready_o, out_valid_o, out_data_o, busy_o, done_o, err_o,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/snn_host_sequencer.sv
// Wishbone initiator that pushes one timestep through a neuron core:
// load IMEM spike words, trigger calc, then drain OMEM words onto a stream.
module snn_host_sequencer #(
  parameter int          NUM_AXONS   = 256,
  parameter logic [31:0] IMEM_BASE_0 = 32'h8000_0000,
  parameter logic [31:0] IMEM_BASE_1 = 32'h8001_0000,
  parameter logic [31:0] OMEM_BASE_0 = 32'h8003_0000,
  parameter logic [31:0] OMEM_BASE_1 = 32'h8004_0000,
  parameter logic [31:0] CALC_ADDR   = 32'h8005_0000,
  parameter int          TIMEOUT     = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  snn_host_sequencer_if.master bus
);

  localparam int WORDS = NUM_AXONS / 32;
  localparam int KW    = $clog2(WORDS) + 1;
  localparam logic [KW-1:0] K_LAST   = KW'(WORDS - 1);
  localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LD_GET, LD_BUS, CALC, RD_BUS, RD_PUSH, FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          core_q, core_d;
  logic [31:0]   word_q, word_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          gap_q, gap_d;
  logic [7:0]    tmo_q, tmo_d;

  logic          beat;
  logic          bus_we;
  logic [31:0]   bus_adr;
  logic [31:0]   bus_dat;
  logic [31:0]   word_off;
  logic          last_word;

  assign word_off  = 32'({k_q, 2'b00});
  assign last_word = (k_q == K_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      core_q  <= 1'b0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      gap_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      core_q  <= core_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
    end
  end

  // gap_q forces one idle bus cycle when two beats would otherwise abut
  // (last IMEM write -> calc, calc -> first OMEM read).
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    core_d  = core_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    beat    = 1'b0;
    bus_we  = 1'b0;
    bus_adr = '0;
    bus_dat = '0;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          core_d  = bus.core_i;
          k_d     = '0;
          err_d   = 1'b0;
          gap_d   = 1'b0;
          tmo_d   = '0;
          state_d = LD_GET;
        end
      end
      LD_GET: begin
        if (bus.in_valid_i) begin
          word_d  = bus.in_data_i;
          tmo_d   = '0;
          state_d = LD_BUS;
        end
      end
      LD_BUS: begin
        beat    = 1'b1;
        bus_we  = 1'b1;
        bus_adr = (core_q ? IMEM_BASE_1 : IMEM_BASE_0) + word_off;
        bus_dat = word_q;
        if (bus.wbm_ack_i) begin
          tmo_d = '0;
          if (last_word) begin
            k_d     = '0;
            gap_d   = 1'b1;
            state_d = CALC;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = LD_GET;
          end
        end
      end
      CALC: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else begin
          beat    = 1'b1;
          bus_we  = 1'b1;
          bus_adr = CALC_ADDR;
          bus_dat = 32'h1;
          if (bus.wbm_ack_i) begin
            tmo_d   = '0;
            gap_d   = 1'b1;
            state_d = RD_BUS;
          end
        end
      end
      RD_BUS: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else begin
          beat    = 1'b1;
          bus_adr = (core_q ? OMEM_BASE_1 : OMEM_BASE_0) + word_off;
          if (bus.wbm_ack_i) begin
            tmo_d   = '0;
            rdata_d = bus.wbm_dat_i;
            state_d = RD_PUSH;
          end
        end
      end
      RD_PUSH: begin
        if (bus.out_ready_i) begin
          if (last_word) begin
            state_d = FINISH;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = RD_BUS;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A stalled beat gives up after TIMEOUT cycles and skips the rest of the run.
    if (beat && !bus.wbm_ack_i) begin
      if (tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        tmo_d   = '0;
        state_d = FINISH;
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
    end
  end

  assign bus.wbm_cyc_o   = beat;
  assign bus.wbm_stb_o   = beat;
  assign bus.wbm_we_o    = bus_we;
  assign bus.wbm_sel_o   = beat ? 4'hF : 4'h0;
  assign bus.wbm_adr_o   = bus_adr;
  assign bus.wbm_dat_o   = bus_dat;
  assign bus.in_ready_o  = (state_q == LD_GET);
  assign bus.out_valid_o = (state_q == RD_PUSH);
  assign bus.out_data_o  = rdata_q;
  assign bus.busy_o      = (state_q != IDLE) && (state_q != FINISH);
  assign bus.done_o      = (state_q == FINISH);
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_snn_host_sequencer.sv
// Scoreboard bench for snn_host_sequencer: expected bus beats and output
// words are queued at stimulus time and popped by independent monitors.
module tb_snn_host_sequencer;

  localparam int          WORDS = 8;
  localparam logic [31:0] IMEM0 = 32'h8000_0000;
  localparam logic [31:0] IMEM1 = 32'h8001_0000;
  localparam logic [31:0] OMEM0 = 32'h8003_0000;
  localparam logic [31:0] OMEM1 = 32'h8004_0000;
  localparam logic [31:0] CALCA = 32'h8005_0000;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snn_host_sequencer_if sif ();

  snn_host_sequencer dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (sif)
  );

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  logic        err_at_done = 1'b0;
  beat_t       exp_beat[$];
  logic [31:0] exp_out[$];
  int          ack_delay = 1;
  int          out_stall = 0;
  bit          stray_ack = 1'b0;
  bit          hang_en = 1'b0;
  logic [31:0] hang_adr = '0;
  bit          prev_acc = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Wishbone slave: acks after ack_delay extra cycles, OMEM reads return A0000000+index.
  initial begin
    int age;
    age = 0;
    sif.wbm_ack_i = 1'b0;
    sif.wbm_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (sif.wbm_cyc_o) begin
        age++;
        sif.wbm_ack_i = (age > ack_delay) &&
                        !(hang_en && sif.wbm_we_o && sif.wbm_adr_o == hang_adr);
        sif.wbm_dat_i = sif.wbm_we_o ? 32'h0 :
                        32'hA000_0000 + ((sif.wbm_adr_o & 32'h0000_FFFF) >> 2);
      end else begin
        age = 0;
        sif.wbm_ack_i = stray_ack;
        sif.wbm_dat_i = 32'hDEAD_BEEF;
      end
    end
  end

  // Output consumer: holds ready low for out_stall cycles per presented word.
  initial begin
    int stall;
    stall = 0;
    sif.out_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sif.out_ready_i) begin
        sif.out_ready_i = 1'b0;
        stall = 0;
      end else if (sif.out_valid_o) begin
        if (stall >= out_stall) sif.out_ready_i = 1'b1;
        else stall++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_acc = 1'b0;
    end else begin
      if (prev_acc) checkOutput("bus_gap", sif.wbm_cyc_o, 0);
      if (sif.in_ready_o || sif.out_valid_o) checkOutput("idle_bus", sif.wbm_cyc_o, 0);
      if (sif.wbm_cyc_o) begin
        checkOutput("stb_eq_cyc", sif.wbm_stb_o, 1);
        checkOutput("sel", sif.wbm_sel_o, 4'hF);
        checkOutput("beat_expected", exp_beat.size() != 0, 1);
        if (exp_beat.size() != 0) begin
          checkOutput("bus_we", sif.wbm_we_o, exp_beat[0].we);
          checkOutput("bus_adr", sif.wbm_adr_o, exp_beat[0].adr);
          if (exp_beat[0].we) checkOutput("bus_dat", sif.wbm_dat_o, exp_beat[0].dat);
          if (sif.wbm_ack_i) void'(exp_beat.pop_front());
        end
      end
      prev_acc = sif.wbm_cyc_o && sif.wbm_ack_i;
    end
  end

  always @(negedge clk) begin
    if (!rst && sif.out_valid_o) begin
      checkOutput("out_expected", exp_out.size() != 0, 1);
      if (exp_out.size() != 0) begin
        checkOutput("out_data", sif.out_data_o, exp_out[0]);
        if (sif.out_ready_i) void'(exp_out.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && sif.done_o) begin
      done_cnt++;
      err_at_done = sif.err_o;
      checkOutput("busy_at_done", sif.busy_o, 0);
    end
  end

  task automatic pushExpect(input bit core, input logic [31:0] base, input logic [31:0] step,
                            input int hang_idx);
    beat_t b;
    for (int k = 0; k < WORDS; k++) begin
      if (hang_idx < 0 || k <= hang_idx) begin
        b.we = 1'b1;
        b.adr = (core ? IMEM1 : IMEM0) + 32'(4 * k);
        b.dat = base + step * 32'(k);
        exp_beat.push_back(b);
      end
    end
    if (hang_idx < 0) begin
      b.we = 1'b1;
      b.adr = CALCA;
      b.dat = 32'h1;
      exp_beat.push_back(b);
      for (int k = 0; k < WORDS; k++) begin
        b.we = 1'b0;
        b.adr = (core ? OMEM1 : OMEM0) + 32'(4 * k);
        b.dat = 32'h0;
        exp_beat.push_back(b);
        exp_out.push_back(32'hA000_0000 + 32'(k));
      end
    end
  endtask

  task automatic startRun(input bit core);
    sif.start_i = 1'b1;
    sif.core_i = core;
    @(posedge clk);
    #1;
    sif.start_i = 1'b0;
    checkOutput("busy_after_start", sif.busy_o, 1);
    checkOutput("err_cleared", sif.err_o, 0);
  endtask

  task automatic feedWords(input logic [31:0] base, input logic [31:0] step, input int n,
                           input int gap, input bit poke, input bit core);
    bit got;
    for (int k = 0; k < n; k++) begin
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      sif.in_valid_i = 1'b1;
      sif.in_data_i = base + step * 32'(k);
      got = 1'b0;
      for (int t = 0; t < 1000 && !got; t++) begin
        @(negedge clk);
        got = sif.in_ready_o;
        @(posedge clk);
        #1;
      end
      sif.in_valid_i = 1'b0;
      checkOutput("in_handshake", got, 1);
      if (!got) break;
      if (poke && k == 1) begin
        sif.start_i = 1'b1;
        sif.core_i = ~core;
        @(posedge clk);
        #1;
        sif.start_i = 1'b0;
        sif.core_i = core;
      end
    end
  endtask

  task automatic applyStimulus(input bit core, input logic [31:0] base, input logic [31:0] step,
                               input int gap, input int stall, input int hang_idx,
                               input bit poke);
    int d0;
    int len;
    out_stall = stall;
    hang_en = (hang_idx >= 0);
    hang_adr = (core ? IMEM1 : IMEM0) + 32'(4 * (hang_idx >= 0 ? hang_idx : 0));
    pushExpect(core, base, step, hang_idx);
    d0 = done_cnt;
    startRun(core);
    feedWords(base, step, hang_idx < 0 ? WORDS : hang_idx + 1, gap, poke, core);
    if (hang_idx >= 0) begin
      len = 0;
      while (sif.wbm_cyc_o && len < 400) begin
        @(negedge clk);
        if (sif.wbm_cyc_o) len++;
      end
      checkOutput("timeout_len", len, 255);
    end
    for (int t = 0; t < 5000 && done_cnt == d0; t++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("done_seen", done_cnt != d0, 1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("done_pulses", done_cnt - d0, 1);
    checkOutput("err_at_done", err_at_done, hang_idx >= 0);
    checkOutput("err_sticky", sif.err_o, hang_idx >= 0);
    checkOutput("beats_left", exp_beat.size(), hang_idx >= 0 ? 1 : 0);
    checkOutput("outs_left", exp_out.size(), 0);
    exp_beat.delete();
    exp_out.delete();
    hang_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=expired required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  d0;
    bit  got;
    sif.start_i = 1'b0;
    sif.core_i = 1'b0;
    sif.in_valid_i = 1'b0;
    sif.in_data_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cyc", sif.wbm_cyc_o, 0);
    checkOutput("rst_stb", sif.wbm_stb_o, 0);
    checkOutput("rst_we", sif.wbm_we_o, 0);
    checkOutput("rst_sel", sif.wbm_sel_o, 0);
    checkOutput("rst_adr", sif.wbm_adr_o, 0);
    checkOutput("rst_busy", sif.busy_o, 0);
    checkOutput("rst_done", sif.done_o, 0);
    checkOutput("rst_err", sif.err_o, 0);
    checkOutput("rst_in_ready", sif.in_ready_o, 0);
    checkOutput("rst_out_valid", sif.out_valid_o, 0);
    checkOutput("rst_out_data", sif.out_data_o, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] core 0 basic run");
    applyStimulus(1'b0, 32'h0, 32'h1111_1111, 0, 0, -1, 1'b0);

    $display("[TB] core 1 run with single-cycle acks");
    ack_delay = 0;
    applyStimulus(1'b1, 32'hDEAD_0000, 32'h1, 0, 0, -1, 1'b0);
    ack_delay = 1;

    $display("[TB] stalled input and output with stray acks");
    stray_ack = 1'b1;
    applyStimulus(1'b0, 32'h5A5A_5A5A, 32'h0101_0101, 5, 10, -1, 1'b0);
    stray_ack = 1'b0;

    $display("[TB] ack timeout on third IMEM write");
    applyStimulus(1'b0, 32'h1234_5678, 32'h10, 0, 0, 2, 1'b0);

    $display("[TB] start pulsed while busy");
    applyStimulus(1'b0, 32'hCAFE_0000, 32'h3, 0, 0, -1, 1'b1);

    $display("[TB] reset during OMEM read");
    pushExpect(1'b0, 32'h0F0F_0000, 32'h1, -1);
    d0 = done_cnt;
    startRun(1'b0);
    feedWords(32'h0F0F_0000, 32'h1, WORDS, 0, 1'b0, 1'b0);
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = sif.wbm_cyc_o && !sif.wbm_we_o;
    end
    checkOutput("reached_rd_bus", got, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_cyc", sif.wbm_cyc_o, 0);
    checkOutput("abort_stb", sif.wbm_stb_o, 0);
    checkOutput("abort_out_valid", sif.out_valid_o, 0);
    checkOutput("abort_busy", sif.busy_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_beat.delete();
    exp_out.delete();
    repeat (20) @(posedge clk);
    #1;
    checkOutput("abort_no_done", done_cnt - d0, 0);

    $display("[TB] fresh core 1 run after reset");
    applyStimulus(1'b1, 32'h0000_FFFF, 32'h0001_0000, 0, 0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
